// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback path: request record and
// address/data widths used by the arbiter and its MDU result queue.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_writeback_arbiter_fifo.sv
// Circular queue of pending MDU writebacks with per-entry valid bits that a
// younger pipeline write to the same register can clear in place.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  wb_req_t                           push_entry,
    input  logic                              pop,
    input  logic                              inval,
    input  logic [REG_ADDR_W-1:0]             inval_addr,
    output wb_req_t                           head,
    output logic [CW-1:0]                     count,
    output logic                              full,
    output logic [DEPTH-1:0]                  entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_addr
);

    wb_req_t       mem [DEPTH];
    wb_req_t       push_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    // An entry arriving alongside a same-register pipeline write is already stale.
    always_comb begin
        push_q       = push_entry;
        push_q.valid = push_entry.valid && !(inval && (push_entry.addr == inval_addr));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inval && mem[i].valid && (mem[i].addr == inval_addr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= push_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = mem[i].valid;
            entry_addr[i]  = mem[i].addr;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Single register-file write port shared by the in-order pipeline (priority)
// and queued MDU results; exports a mask of registers still in flight.
module rf_writeback_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIPE_WE,
    input  logic [REG_ADDR_W-1:0] PIPE_ADDR,
    input  logic [XLEN-1:0]       PIPE_DATA,
    input  logic                  MDU_VALID,
    output logic                  MDU_READY,
    input  logic [REG_ADDR_W-1:0] MDU_ADDR,
    input  logic [XLEN-1:0]       MDU_DATA,
    output logic                  WRITE_ENABLE,
    output logic [REG_ADDR_W-1:0] WB_ADDRESS,
    output logic [XLEN-1:0]       WRITE_DATA,
    output logic [31:0]           PENDING_MASK
);

    localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    wb_req_t                          push_entry;
    wb_req_t                          head;
    logic [CW-1:0]                    count;
    logic                             full;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
    logic                             pipe_issue;
    logic                             pop;
    logic                             mdu_issue;
    logic                             push;
    logic [31:0]                      mask;

    assign MDU_READY  = RESET && !full;
    assign pipe_issue = PIPE_WE && (PIPE_ADDR != '0);
    // Stale heads are popped too; they burn the slot but issue nothing.
    assign pop        = !pipe_issue && (count != '0);
    assign mdu_issue  = pop && head.valid;
    assign push       = MDU_VALID && MDU_READY && (MDU_ADDR != '0);

    always_comb begin
        push_entry       = '0;
        push_entry.valid = 1'b1;
        push_entry.addr  = MDU_ADDR;
        push_entry.data  = XLEN_DEF'(MDU_DATA);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (CLK),
        .reset       (RESET),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .inval       (pipe_issue),
        .inval_addr  (PIPE_ADDR),
        .head        (head),
        .count       (count),
        .full        (full),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            WRITE_ENABLE <= 1'b0;
            WB_ADDRESS   <= '0;
            WRITE_DATA   <= '0;
        end else begin
            WRITE_ENABLE <= pipe_issue || mdu_issue;
            if (pipe_issue) begin
                WB_ADDRESS <= PIPE_ADDR;
                WRITE_DATA <= PIPE_DATA;
            end else if (mdu_issue) begin
                WB_ADDRESS <= head.addr;
                WRITE_DATA <= head.data[XLEN-1:0];
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                mask[entry_addr[i]] = 1'b1;
            end
        end
        mask[0] = 1'b0;
    end

    assign PENDING_MASK = mask;

endmodule
